// File: rtl/accumulate_32bit.sv
// rtl/accumulate_32bit.sv - streaming 32-bit unsigned accumulator with sticky carry flag
// Sums len operands through a parallel-prefix adder; the result is held until it is taken.

module accumulate_32bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [31:0] add_sum;
  logic        add_cout;

  Adder_32bit u_adder (
    .a    (acc_q),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        // in_ready is high for the whole of ACC, so in_valid alone marks a beat
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// Kogge-Stone style recursive-doubling adder: each level doubles the span of
// the group generate/propagate terms, so after five levels g_s[5][i] is the carry out of bit i.
module Adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g_s [0:5];
  logic [31:0] p_s [0:5];

  always_comb begin
    g_s[0] = a & b;
    p_s[0] = a ^ b;
    for (int l = 0; l < 5; l++) begin
      g_s[l+1] = g_s[l] | (p_s[l] & (g_s[l] << (1 << l)));
      p_s[l+1] = p_s[l] & ((p_s[l] << (1 << l)) | ~({32{1'b1}} << (1 << l)));
    end
  end

  assign sum  = p_s[0] ^ {g_s[5][30:0], 1'b0};
  assign cout = g_s[5][31];

endmodule

// File: tb/tb_accumulate_32bit.sv
// tb/tb_accumulate_32bit.sv - directed self-checking bench for accumulate_32bit

module tb_accumulate_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  accumulate_32bit #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"},   out_sum,   0);
    check({tag, "_out_ovf"},   out_ovf,   0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;

    // three back-to-back beats
    start_run(8'd3);
    check("acc_busy", busy, 1);
    check("acc_in_ready", in_ready, 1);
    check("acc_out_valid", out_valid, 0);
    beat(32'd1);
    beat(32'd2);
    check("len3_not_done", out_valid, 0);
    beat(32'd3);
    check("len3_valid", out_valid, 1);
    check("len3_sum", out_sum, 32'h6);
    check("len3_ovf", out_ovf, 0);
    check("len3_in_ready", in_ready, 0);
    take();
    check("len3_released", out_valid, 0);
    check("len3_idle", busy, 0);

    // wrap sets overflow
    start_run(8'd2);
    beat(32'hFFFF_FFFF);
    beat(32'h0000_0002);
    check("wrap_sum", out_sum, 32'h1);
    check("wrap_ovf", out_ovf, 1);
    take();

    // overflow is sticky across later non-carrying adds
    start_run(8'd3);
    beat(32'hFFFF_FFFF);
    beat(32'h0000_0001);
    beat(32'h0000_0005);
    check("sticky_sum", out_sum, 32'h5);
    check("sticky_ovf", out_ovf, 1);
    take();

    // empty sum; in_valid during start must not be taken
    in_valid = 1'b1;
    in_data  = 32'h55;
    start_run(8'd0);
    in_valid = 1'b0;
    check("len0_valid", out_valid, 1);
    check("len0_sum", out_sum, 0);
    check("len0_ovf", out_ovf, 0);
    take();

    // bubbles, plus a stray start during ACC
    start_run(8'd4);
    beat(32'h10);
    tick();
    beat(32'h20);
    start = 1'b1; len = 8'd1;
    tick();
    tick();
    start = 1'b0;
    beat(32'h30);
    tick();
    check("bubble_not_done", out_valid, 0);
    check("bubble_partial", out_sum, 32'h60);
    beat(32'h40);
    check("bubble_valid", out_valid, 1);
    check("bubble_sum", out_sum, 32'hA0);
    take();

    // hold result with back-pressure and start pulsed
    start_run(8'd1);
    beat(32'h9);
    start = 1'b1; len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, 32'h9);
    end
    start = 1'b0;
    take();
    check("hold_idle", busy, 0);
    check("hold_released", out_valid, 0);

    // reset mid-ACC discards the partial sum
    start_run(8'd3);
    beat(32'h5);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h100; start = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    check_idle_zero("rst_acc");
    start_run(8'd1);
    beat(32'h7);
    check("after_rst_sum", out_sum, 32'h7);
    check("after_rst_ovf", out_ovf, 0);

    // reset in DONE with out_ready also high
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check_idle_zero("rst_done");

    // maximum length: 255 beats of 2^25 -> 0x1_FE00_0000
    start_run(8'hFF);
    for (int i = 0; i < 254; i++) begin
      beat(32'h0200_0000);
    end
    check("max_not_done", out_valid, 0);
    check("max_busy", in_ready, 1);
    beat(32'h0200_0000);
    check("max_valid", out_valid, 1);
    check("max_sum", out_sum, 32'hFE00_0000);
    check("max_ovf", out_ovf, 1);
    take();
    check("max_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
